// File: rtl/hub75_fb_writer_if.sv
// Pixel stream bundle feeding the frame-buffer writer: raster-ordered
// 24-bit RGB beats with a start-of-frame marker and valid/ready flow control.
interface hub75_fb_writer_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;

  // Upstream pixel source
  modport master (
    output s_valid,
    output s_data,
    output s_sof,
    input  s_ready
  );

  // Frame-buffer writer side
  modport slave (
    input  s_valid,
    input  s_data,
    input  s_sof,
    output s_ready
  );
endinterface

// File: rtl/hub75_fb_writer.sv
// Double-buffered frame-buffer writer for the HUB75 display engine.
// Pixels are written into the back bank; the finished bank is handed to the
// display only on a display frame boundary, so a frame is never shown torn.
module hub75_fb_writer #(
  parameter int ADDR_W       = 15,
  parameter int FRAME_PIXELS = 4096,
  parameter int CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  hub75_fb_writer_if.slave      s_pix,
  input  logic                  frame_sync,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [31:0]           wr_data,
  output logic                  disp_bank,
  output logic                  swap_pulse,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      sof_err_cnt
);

  localparam int                IDX_W    = ADDR_W - 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_SWAP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_wr_bank, w_wr_bank_nxt;
  logic               r_disp_bank, w_disp_bank_nxt;
  logic               r_fs_q;
  logic               r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0]  r_wr_addr, w_wr_addr_nxt;
  logic [31:0]        r_wr_data, w_wr_data_nxt;
  logic               r_swap, w_swap_nxt;
  logic [CNT_W-1:0]   r_drop_cnt, w_drop_cnt_nxt;
  logic [CNT_W-1:0]   r_sof_err_cnt, w_sof_err_cnt_nxt;

  logic               w_ready;
  logic               w_accept;
  logic               w_sync_edge;

  // Ready is held low during reset and while a finished frame awaits the swap
  assign w_ready        = resetn & enable & (r_state != WAIT_SWAP);
  assign s_pix.s_ready  = w_ready;
  assign w_accept       = s_pix.s_valid & w_ready;
  assign w_sync_edge    = frame_sync & ~r_fs_q;

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign disp_bank   = r_disp_bank;
  assign swap_pulse  = r_swap;
  assign drop_cnt    = r_drop_cnt;
  assign sof_err_cnt = r_sof_err_cnt;

  // Next-state, bank handover and registered write-port contents
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_wr_bank_nxt     = r_wr_bank;
    w_disp_bank_nxt   = r_disp_bank;
    w_wr_en_nxt       = 1'b0;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_data_nxt     = r_wr_data;
    w_swap_nxt        = 1'b0;
    w_drop_cnt_nxt    = r_drop_cnt;
    w_sof_err_cnt_nxt = r_sof_err_cnt;

    if (!enable) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (s_pix.s_sof) begin
              w_wr_en_nxt   = 1'b1;
              w_wr_addr_nxt = {r_wr_bank, {IDX_W{1'b0}}};
              w_wr_data_nxt = {8'h00, s_pix.s_data};
              w_idx_nxt     = IDX_W'(1);
              w_state_nxt   = WRITE;
            end else if (r_drop_cnt != CNT_MAX) begin
              w_drop_cnt_nxt = r_drop_cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (w_accept) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_data_nxt = {8'h00, s_pix.s_data};
            if (s_pix.s_sof) begin
              w_wr_addr_nxt = {r_wr_bank, {IDX_W{1'b0}}};
              w_idx_nxt     = IDX_W'(1);
              if (r_sof_err_cnt != CNT_MAX) begin
                w_sof_err_cnt_nxt = r_sof_err_cnt + CNT_W'(1);
              end
            end else begin
              w_wr_addr_nxt = {r_wr_bank, r_idx};
              if (r_idx == LAST_IDX) begin
                w_idx_nxt   = '0;
                w_state_nxt = WAIT_SWAP;
              end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
              end
            end
          end
        end
        WAIT_SWAP: begin
          w_idx_nxt = '0;
          if (w_sync_edge) begin
            w_disp_bank_nxt = r_wr_bank;
            w_wr_bank_nxt   = ~r_wr_bank;
            w_swap_nxt      = 1'b1;
            w_state_nxt     = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers; reset makes the display read bank 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_wr_bank     <= 1'b1;
      r_disp_bank   <= 1'b0;
      r_fs_q        <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_swap        <= 1'b0;
      r_drop_cnt    <= '0;
      r_sof_err_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_wr_bank     <= w_wr_bank_nxt;
      r_disp_bank   <= w_disp_bank_nxt;
      r_fs_q        <= frame_sync;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_swap        <= w_swap_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
      r_sof_err_cnt <= w_sof_err_cnt_nxt;
    end
  end

endmodule
